// File: rtl/mem_arbiter_nch_pkg.sv
// Shared types for the multi-channel memory arbiter: FSM state encoding,
// arbitration policy codes and the read-tag record carried by the tag pipe.
package mem_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_e;

    localparam int POL_FIXED = 0;
    localparam int POL_RR    = 1;

    // Tag ids are sized for the largest supported channel count (8) so the
    // struct can live in a non-parameterised package.
    localparam int MAX_CH   = 8;
    localparam int TAG_ID_W = $clog2(MAX_CH);

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } arb_tag_t;

endpackage

// File: rtl/mem_arbiter_nch_if.sv
// Bus bundle between the cache miss engines / store port and the memory.
//
// Handshake: ch_req[i] is a level request held for the whole line fill; a read
// is issued on every cycle where ch_grant[i] and ch_req[i] are both high, and
// its data returns MEM_LAT cycles later on ch_rd_valid[i] with rd_data.
// wr_req is held with stable wr_addr/wr_data until wr_ack pulses for one cycle,
// which is the cycle the store is presented to memory.
interface mem_arbiter_nch_if #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic [NUM_CH-1:0]        ch_req;
    logic [NUM_CH*ADDR_W-1:0] ch_addr;
    logic [NUM_CH-1:0]        ch_grant;
    logic [NUM_CH-1:0]        ch_rd_valid;
    logic [DATA_W-1:0]        rd_data;
    logic                     wr_req;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     wr_ack;
    logic                     mem_en;
    logic                     mem_wr;
    logic [ADDR_W-1:0]        mem_addr;
    logic [DATA_W-1:0]        mem_wdata;
    logic [DATA_W-1:0]        mem_rdata;
    logic                     mem_data_valid;
    logic                     tag_err;

    // Arbiter side.
    modport slave (
        input  ch_req, ch_addr, wr_req, wr_addr, wr_data, mem_rdata, mem_data_valid,
        output ch_grant, ch_rd_valid, rd_data, wr_ack, mem_en, mem_wr, mem_addr,
        output mem_wdata, tag_err
    );

    // Requester / memory side.
    modport master (
        output ch_req, ch_addr, wr_req, wr_addr, wr_data, mem_rdata, mem_data_valid,
        input  ch_grant, ch_rd_valid, rd_data, wr_ack, mem_en, mem_wr, mem_addr,
        input  mem_wdata, tag_err
    );
endinterface

// File: rtl/mem_arbiter_nch_tag_pipe.sv
// MEM_LAT-deep shift register of read tags. One entry is pushed every cycle
// (invalid on non-read cycles) so the tail always lines up with the memory
// read latency; the tail is the last register stage.
module arb_tag_pipe
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  arb_tag_t push_i,
    output arb_tag_t tail_o
);

    arb_tag_t pipe_q [MEM_LAT];

    // Shift tags one stage per cycle; reset drops every in-flight tag.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MEM_LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= push_i;
            for (int i = 1; i < MEM_LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign tail_o = pipe_q[MEM_LAT-1];

endmodule

// File: rtl/mem_arbiter_nch.sv
// Shares one multicycle memory between NUM_CH read miss engines and a
// single-cycle store port. Stores win in IDLE; otherwise one channel owns the
// memory for its whole fill. Returning data is routed by a tag pipe so it
// reaches its issuer even after that channel lost the grant.
// Optional build macro: ARB_PERF_CNT_EN adds per-channel grant/wait counters.
module mem_arbiter_nch
    import mem_arb_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int MEM_LAT  = 4,
    parameter int POLICY   = 0,
    parameter int MAX_HOLD = 0
) (
    input  logic       clk,
    input  logic       rst,
    mem_arbiter_nch_if.slave bus,
    output arb_state_e dbg_state_o
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [NUM_CH*32-1:0] perf_grant_cycles,
    output logic [NUM_CH*32-1:0] perf_wait_cycles
`endif
);

    localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    arb_state_e          state_q, state_d;
    logic [TAG_ID_W-1:0] owner_q, owner_d;
    logic [TAG_ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                tag_err_q;

    logic [NUM_CH-1:0]   own_onehot;
    logic                own_req;
    logic [ADDR_W-1:0]   own_addr;
    logic [TAG_ID_W-1:0] win;

    logic [NUM_CH-1:0]   grant;
    logic                mem_en, mem_wr, wr_ack;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    arb_tag_t            push, tail;

    // Fixed: highest requesting index. Round-robin: first requester at or
    // after ptr, wrapping.
    function automatic logic [TAG_ID_W-1:0] pick_winner(
        input logic [NUM_CH-1:0]   req,
        input logic [TAG_ID_W-1:0] ptr
    );
        logic [TAG_ID_W-1:0] w;
        logic                found;
        int                  idx;
        w     = '0;
        found = 1'b0;
        if (POLICY == POL_RR) begin
            for (int j = 0; j < NUM_CH; j++) begin
                idx = (int'(ptr) + j) % NUM_CH;
                if (!found && req[idx]) begin
                    w     = TAG_ID_W'(idx);
                    found = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (req[i]) begin
                    w = TAG_ID_W'(i);
                end
            end
        end
        return w;
    endfunction

    // Decode the registered owner into its one-hot, request and address.
    always_comb begin
        own_onehot = '0;
        own_req    = 1'b0;
        own_addr   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (owner_q == TAG_ID_W'(i)) begin
                own_onehot[i] = 1'b1;
                own_req       = bus.ch_req[i];
                own_addr      = bus.ch_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    assign win = pick_winner(bus.ch_req, rr_ptr_q);

    // Next-state and memory-side outputs; reset forces the memory port quiet.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_ptr_d  = rr_ptr_q;
        hold_d    = hold_q;
        grant     = '0;
        mem_en    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        wr_ack    = 1'b0;
        push      = '0;
        case (state_q)
            IDLE: begin
                if (bus.wr_req) begin
                    mem_en    = 1'b1;
                    mem_wr    = 1'b1;
                    mem_addr  = bus.wr_addr;
                    mem_wdata = bus.wr_data;
                    wr_ack    = 1'b1;
                end else if (|bus.ch_req) begin
                    state_d  = OWN;
                    owner_d  = win;
                    hold_d   = '0;
                    rr_ptr_d = (win == TAG_ID_W'(NUM_CH - 1)) ? '0 : win + TAG_ID_W'(1);
                end
            end
            OWN: begin
                grant = own_onehot;
                if (own_req) begin
                    mem_en     = 1'b1;
                    mem_addr   = own_addr;
                    push.valid = 1'b1;
                    push.id    = owner_q;
                    hold_d     = hold_q + HOLD_W'(1);
                    if (MAX_HOLD > 0 && int'(hold_q) == MAX_HOLD - 1) begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            mem_en    = 1'b0;
            mem_wr    = 1'b0;
            mem_addr  = '0;
            mem_wdata = '0;
            wr_ack    = 1'b0;
            push      = '0;
        end
    end

    // FSM, owner, round-robin pointer and tenure length registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            hold_q   <= hold_d;
        end
    end

    arb_tag_pipe #(.MEM_LAT(MEM_LAT)) u_tag_pipe (
        .clk    (clk),
        .rst    (rst),
        .push_i (push),
        .tail_o (tail)
    );

    // Sticky flag for returning data that no tracked read accounts for.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_err_q <= 1'b0;
        end else if (bus.mem_data_valid && !tail.valid) begin
            tag_err_q <= 1'b1;
        end
    end

    // Route returning data to the channel recorded in the tail tag.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            bus.ch_rd_valid[i] = bus.mem_data_valid & tail.valid & (tail.id == TAG_ID_W'(i));
        end
    end

    assign bus.rd_data   = bus.mem_rdata;
    assign bus.ch_grant  = grant;
    assign bus.wr_ack    = wr_ack;
    assign bus.mem_en    = mem_en;
    assign bus.mem_wr    = mem_wr;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.tag_err   = tag_err_q;
    assign dbg_state_o   = state_q;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_grant_q [NUM_CH];
    logic [31:0] perf_wait_q  [NUM_CH];

    // Saturating per-channel counters of owned cycles and starved cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                perf_grant_q[i] <= '0;
                perf_wait_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (grant[i] && perf_grant_q[i] != '1) begin
                    perf_grant_q[i] <= perf_grant_q[i] + 32'd1;
                end
                if (bus.ch_req[i] && !grant[i] && perf_wait_q[i] != '1) begin
                    perf_wait_q[i] <= perf_wait_q[i] + 32'd1;
                end
            end
        end
    end

    // Flatten counters onto the output buses.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            perf_grant_cycles[i*32 +: 32] = perf_grant_q[i];
            perf_wait_cycles[i*32 +: 32]  = perf_wait_q[i];
        end
    end
`endif

endmodule
